// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush sequencer: load-use bubbles, taken-branch flushes, data memory
// wait freezes with timeout, and saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  idex_memread_i,
    input  logic [REG_ADDR_W-1:0] idex_rd_i,
    input  logic [REG_ADDR_W-1:0] ifid_rs1_i,
    input  logic [REG_ADDR_W-1:0] ifid_rs2_i,
    input  logic                  exmem_branch_i,
    input  logic                  exmem_zero_i,
    input  logic                  exmem_memread_i,
    input  logic                  exmem_memwrite_i,
    input  logic                  mem_ready_i,
    output logic                  mem_req_o,
    output logic                  pc_write_o,
    output logic                  pc_src_o,
    output logic                  ifid_write_o,
    output logic                  ifid_flush_o,
    output logic                  idex_write_o,
    output logic                  idex_flush_o,
    output logic                  exmem_hold_o,
    output logic                  memwb_bubble_o,
    output logic                  mem_timeout_err_o,
    output logic [CNT_W-1:0]      stall_count_o,
    output logic [CNT_W-1:0]      flush_count_o
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic in_err, mem_acc, freeze, taken, load_use, stall_inc;

    always_comb begin
        in_err  = (state_q == StError);
        mem_acc = exmem_memread_i | exmem_memwrite_i;
        freeze  = !in_err && mem_acc && !mem_ready_i;
        // EX/MEM is held during a freeze, so its branch is re-evaluated on release.
        taken   = !in_err && !freeze && exmem_branch_i && exmem_zero_i;
        load_use = !in_err && !freeze && !taken && idex_memread_i
                   && (idex_rd_i != '0)
                   && ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));
        stall_inc = freeze | load_use | in_err;
    end

    always_comb begin
        mem_req_o      = 1'b0;
        pc_write_o     = 1'b1;
        pc_src_o       = 1'b0;
        ifid_write_o   = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_write_o   = 1'b1;
        idex_flush_o   = 1'b0;
        exmem_hold_o   = 1'b0;
        memwb_bubble_o = 1'b0;
        if (!reset) begin
            if (in_err || freeze) begin
                pc_write_o     = 1'b0;
                ifid_write_o   = 1'b0;
                idex_write_o   = 1'b0;
                exmem_hold_o   = 1'b1;
                memwb_bubble_o = 1'b1;
            end else if (taken) begin
                pc_src_o     = 1'b1;
                ifid_flush_o = 1'b1;
                idex_flush_o = 1'b1;
            end else if (load_use) begin
                pc_write_o   = 1'b0;
                ifid_write_o = 1'b0;
                idex_flush_o = 1'b1;
            end
            if (!in_err) begin
                mem_req_o = mem_acc;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        unique case (state_q)
            StRun, StMemWait: begin
                if (freeze) begin
                    if (wait_cnt_q == WaitLast) begin
                        state_d = StError;
                    end else begin
                        state_d    = StMemWait;
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = StRun;
                end
            end
            StError: state_d = StError;
            default: state_d = StRun;
        endcase

        stall_cnt_d = (stall_inc && stall_cnt_q != CntMax) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = (taken && flush_cnt_q != CntMax) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_timeout_err_o = in_err;
    assign stall_count_o     = stall_cnt_q;
    assign flush_count_o     = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: driver pushes expected controls/counters,
// monitor pops and compares on the falling edge.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        idex_memread = 1'b0;
    logic [4:0]  idex_rd = '0, ifid_rs1 = '0, ifid_rs2 = '0;
    logic        exmem_branch = 1'b0, exmem_zero = 1'b0;
    logic        exmem_memread = 1'b0, exmem_memwrite = 1'b0, mem_ready = 1'b0;
    logic        mem_req, pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush;
    logic        exmem_hold, memwb_bubble, mem_timeout_err;
    logic [15:0] stall_count, flush_count;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (5),
        .MEM_TIMEOUT(15),
        .CNT_W      (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .idex_memread_i   (idex_memread),
        .idex_rd_i        (idex_rd),
        .ifid_rs1_i       (ifid_rs1),
        .ifid_rs2_i       (ifid_rs2),
        .exmem_branch_i   (exmem_branch),
        .exmem_zero_i     (exmem_zero),
        .exmem_memread_i  (exmem_memread),
        .exmem_memwrite_i (exmem_memwrite),
        .mem_ready_i      (mem_ready),
        .mem_req_o        (mem_req),
        .pc_write_o       (pc_write),
        .pc_src_o         (pc_src),
        .ifid_write_o     (ifid_write),
        .ifid_flush_o     (ifid_flush),
        .idex_write_o     (idex_write),
        .idex_flush_o     (idex_flush),
        .exmem_hold_o     (exmem_hold),
        .memwb_bubble_o   (memwb_bubble),
        .mem_timeout_err_o(mem_timeout_err),
        .stall_count_o    (stall_count),
        .flush_count_o    (flush_count)
    );

    always #5 clk = ~clk;

    // ctrl = {mem_req, pc_write, pc_src, ifid_write, ifid_flush,
    //         idex_write, idex_flush, exmem_hold, memwb_bubble, mem_timeout_err}
    localparam logic [9:0] NORM = 10'b0_1_0_1_0_1_0_0_0_0;
    localparam logic [9:0] LU   = 10'b0_0_0_0_0_1_1_0_0_0;
    localparam logic [9:0] TK   = 10'b0_1_1_1_1_1_1_0_0_0;
    localparam logic [9:0] FRZ  = 10'b1_0_0_0_0_0_0_1_1_0;
    localparam logic [9:0] ACC  = 10'b1_1_0_1_0_1_0_0_0_0;
    localparam logic [9:0] ACTK = 10'b1_1_1_1_1_1_1_0_0_0;
    localparam logic [9:0] ERR  = 10'b0_0_0_0_0_0_0_1_1_1;

    typedef struct packed {
        logic [9:0]  ctrl;
        logic [15:0] stall;
        logic [15:0] flush;
        logic [15:0] id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    task automatic drv(input logic r, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic br, input logic z, input logic er, input logic ew,
                       input logic rdy, input logic [9:0] ec, input int es, input int ef);
        exp_t e;
        @(posedge clk);
        #1;
        reset          = r;
        idex_memread   = mr;
        idex_rd        = rd;
        ifid_rs1       = rs1;
        ifid_rs2       = rs2;
        exmem_branch   = br;
        exmem_zero     = z;
        exmem_memread  = er;
        exmem_memwrite = ew;
        mem_ready      = rdy;
        e.ctrl  = ec;
        e.stall = 16'(es);
        e.flush = 16'(ef);
        e.id    = 16'(vec_id);
        vec_id++;
        sb.push_back(e);
    endtask

    task automatic idle(input logic [9:0] ec, input int es, input int ef);
        drv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ec, es, ef);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [9:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {mem_req, pc_write, pc_src, ifid_write, ifid_flush,
                       idex_write, idex_flush, exmem_hold, memwb_bubble, mem_timeout_err};
                checks++;
                if (act !== e.ctrl) begin
                    errors++;
                    $display("FAIL ctrl vec %0d: got %b want %b", e.id, act, e.ctrl);
                end
                checks++;
                if (stall_count !== e.stall) begin
                    errors++;
                    $display("FAIL stall_count vec %0d: got %0d want %0d",
                             e.id, stall_count, e.stall);
                end
                checks++;
                if (flush_count !== e.flush) begin
                    errors++;
                    $display("FAIL flush_count vec %0d: got %0d want %0d",
                             e.id, flush_count, e.flush);
                end
            end
        end
    end

    initial begin : stim
        int guard;
        // Reset held with hazards present: enables forced on, counters zero.
        drv(1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, NORM, 0, 0);
        idle(NORM, 0, 0);
        // Load-use on rs2.
        drv(1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LU, 0, 0);
        idle(NORM, 1, 0);
        // Load to x0 never stalls.
        drv(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1, 0);
        // Taken branch beats load-use.
        drv(1'b0, 1'b1, 5'd7, 5'd7, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, TK, 1, 0);
        idle(NORM, 1, 1);
        // Untaken branch lets load-use through.
        drv(1'b0, 1'b1, 5'd4, 5'd4, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LU, 1, 1);
        // Three wait cycles, branch/load-use masked during freeze, branch resolves on release.
        drv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ, 2, 1);
        drv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ, 3, 1);
        drv(1'b0, 1'b1, 5'd6, 5'd6, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, FRZ, 4, 1);
        drv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, ACTK, 5, 1);
        idle(NORM, 5, 2);
        // Zero-wait store.
        drv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ACC, 5, 2);
        // Memory never ready: 15 freeze cycles, then ERROR.
        for (int k = 0; k < 15; k++) begin
            drv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, 5 + k, 2);
        end
        idle(ERR, 20, 2);
        drv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ERR, 21, 2);
        drv(1'b0, 1'b1, 5'd2, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ERR, 22, 2);
        // Reset clears ERROR.
        drv(1'b1, 1'b1, 5'd2, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, NORM, 0, 0);
        idle(NORM, 0, 0);
        // Reset in MEM_WAIT: immediate RUN, wait counter cleared.
        drv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ, 0, 0);
        drv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ, 1, 0);
        drv(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NORM, 0, 0);
        for (int k = 0; k < 14; k++) begin
            drv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ, k, 0);
        end
        drv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ACC, 14, 0);
        idle(NORM, 14, 0);

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
